aes_bus_master: RTL and testbench

Host-side initiator for the AES-128 coprocessor's shared 32-bit bidirectional bus (data/RW/adress/initiate/start/selCypher).
- Accepts a 128-bit block, a 128-bit key and a cipher/decipher select over a valid/ready request port.
- Writes the message buffer, optionally the key buffer, pulses start and waits a fixed compute latency.
- Reads the 4-word result back and presents it on a valid/ready response port.
- Sits between a system-side controller and the coprocessor's bus pins.

---
 rtl/aes_bus_pkg.sv | 37 +++
 rtl/aes_bus_tristate.sv | 29 ++
 rtl/aes_bus_master.sv | 186 ++++++++++++++++++
 tb/tb_aes_bus_master.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_bus_pkg.sv
// Shared types, constants and helpers for the AES coprocessor bus initiator.
package aes_bus_pkg;

    localparam int unsigned WORDS_PER_BLOCK = 4;
    localparam int unsigned BUS_W           = 32;
    localparam int unsigned BLOCK_W         = WORDS_PER_BLOCK * BUS_W;
    localparam int unsigned WCNT_W          = $clog2(WORDS_PER_BLOCK);

    localparam logic ADR_MSG = 1'b0;
    localparam logic ADR_KEY = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        WR_MSG,
        WR_KEY,
        START,
        WAIT,
        RD,
        RESP
    } state_e;

    // Request payload captured on accept
    typedef struct packed {
        logic [BLOCK_W-1:0] msg;
        logic [BLOCK_W-1:0] key;
        logic               key_load;
    } req_t;

    // Word 0 lives in the most significant 32 bits of the block
    function automatic logic [BUS_W-1:0] word_sel(input logic [BLOCK_W-1:0] vec,
                                                  input logic [WCNT_W-1:0]  idx);
        logic [BLOCK_W-1:0] shifted;
        shifted = vec >> (BUS_W * (WORDS_PER_BLOCK - 1 - 32'(idx)));
        return shifted[BUS_W-1:0];
    endfunction

endpackage

// File: rtl/aes_bus_tristate.sv
// Registered output enable and write data for the bidirectional coprocessor bus.
module aes_bus_tristate
    import aes_bus_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             oe_d,
    input  logic [BUS_W-1:0] dout_d,
    output logic [BUS_W-1:0] din,
    inout  wire  [BUS_W-1:0] data
);

    logic             oe_q;
    logic [BUS_W-1:0] dout_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            oe_q   <= 1'b0;
            dout_q <= '0;
        end else begin
            oe_q   <= oe_d;
            dout_q <= dout_d;
        end
    end

    assign data = oe_q ? dout_q : {BUS_W{1'bz}};
    assign din  = data;

endmodule

// File: rtl/aes_bus_master.sv
// Host-side initiator: writes block/key to the AES coprocessor, launches it,
// waits the fixed compute latency and reads the 4-word result back.
module aes_bus_master
    import aes_bus_pkg::*;
#(
    parameter int unsigned ENC_WAIT   = 36,
    parameter int unsigned DEC_WAIT   = 23,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [BLOCK_W-1:0] msg_in,
    input  logic [BLOCK_W-1:0] key_in,
    input  logic               cypher_in,
    input  logic               key_load,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [BLOCK_W-1:0] res_out,
    output logic               busy,
    inout  wire  [BUS_W-1:0]   data,
    output logic               RW,
    output logic               adress,
    output logic               initiate,
    output logic               start,
    output logic               selCypher
);

    localparam int unsigned WAIT_W  = 16;
    localparam int unsigned RD_W    = 8;
    localparam int unsigned RD_LAST = RD_LATENCY + WORDS_PER_BLOCK - 1;

    state_e              state_q, state_d;
    req_t                req_q, req_d;
    logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [RD_W-1:0]     rd_cnt_q, rd_cnt_d;
    logic [BLOCK_W-1:0]  res_q, res_d;
    logic                sel_q, sel_d;
    logic                req_ready_q, req_ready_d;
    logic                res_valid_q, res_valid_d;
    logic                busy_q, busy_d;
    logic                rw_q, rw_d;
    logic                adr_q, adr_d;
    logic                init_q, init_d;
    logic                start_q, start_d;
    logic                oe_d;
    logic [BUS_W-1:0]    wdata_d;
    logic [BUS_W-1:0]    bus_din;
    logic [WCNT_W-1:0]   rd_idx;

    aes_bus_tristate u_tristate (
        .clk    (clk),
        .reset  (reset),
        .oe_d   (oe_d),
        .dout_d (wdata_d),
        .din    (bus_din),
        .data   (data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            req_q       <= '0;
            word_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            rd_cnt_q    <= '0;
            res_q       <= '0;
            sel_q       <= 1'b0;
            req_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            rw_q        <= 1'b0;
            adr_q       <= ADR_MSG;
            init_q      <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            word_cnt_q  <= word_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            res_q       <= res_d;
            sel_q       <= sel_d;
            req_ready_q <= req_ready_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
            rw_q        <= rw_d;
            adr_q       <= adr_d;
            init_q      <= init_d;
            start_q     <= start_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        word_cnt_d = word_cnt_q;
        wait_cnt_d = wait_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        res_d      = res_q;
        sel_d      = sel_q;
        rd_idx     = WCNT_W'(rd_cnt_q - RD_W'(RD_LATENCY));

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    req_d.msg      = msg_in;
                    req_d.key      = key_in;
                    req_d.key_load = key_load;
                    sel_d          = cypher_in;
                    word_cnt_d     = '0;
                    state_d        = WR_MSG;
                end
            end
            WR_MSG: begin
                word_cnt_d = word_cnt_q + WCNT_W'(1);
                if (word_cnt_q == WCNT_W'(WORDS_PER_BLOCK - 1)) begin
                    state_d = req_q.key_load ? WR_KEY : START;
                end
            end
            WR_KEY: begin
                word_cnt_d = word_cnt_q + WCNT_W'(1);
                if (word_cnt_q == WCNT_W'(WORDS_PER_BLOCK - 1)) begin
                    state_d = START;
                end
            end
            START: begin
                wait_cnt_d = sel_q ? WAIT_W'(ENC_WAIT - 1) : WAIT_W'(DEC_WAIT - 1);
                state_d    = WAIT;
            end
            WAIT: begin
                if (wait_cnt_q == '0) begin
                    rd_cnt_d = '0;
                    state_d  = RD;
                end else begin
                    wait_cnt_d = wait_cnt_q - WAIT_W'(1);
                end
            end
            RD: begin
                rd_cnt_d = rd_cnt_q + RD_W'(1);
                // The first RD_LATENCY read cycles carry no valid data
                if (rd_cnt_q >= RD_W'(RD_LATENCY)) begin
                    for (int k = 0; k < WORDS_PER_BLOCK; k++) begin
                        if (rd_idx == WCNT_W'(k)) begin
                            res_d[BLOCK_W-1-BUS_W*k -: BUS_W] = bus_din;
                        end
                    end
                end
                if (rd_cnt_q == RD_W'(RD_LAST)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (res_ready) begin
                    sel_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Bus and handshake outputs are registered from the next state
        req_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        res_valid_d = (state_d == RESP);
        rw_d        = (state_d == WR_MSG) || (state_d == WR_KEY);
        init_d      = rw_d || (state_d == RD);
        adr_d       = (state_d == WR_KEY) ? ADR_KEY : ADR_MSG;
        start_d     = (state_d == START);
        oe_d        = rw_d;
        wdata_d     = word_sel((state_d == WR_KEY) ? req_d.key : req_d.msg, word_cnt_d);
    end

    assign req_ready = req_ready_q;
    assign res_valid = res_valid_q;
    assign res_out   = res_q;
    assign busy      = busy_q;
    assign RW        = rw_q;
    assign adress    = adr_q;
    assign initiate  = init_q;
    assign start     = start_q;
    assign selCypher = sel_q;

endmodule

// File: tb/tb_aes_bus_master.sv
// Bench for aes_bus_master: per-cycle transaction-timeline model plus directed vectors.
module tb_aes_bus_master;

    localparam logic [31:0] PROBE = 32'h5a5a_c3c3;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   req_valid, res_ready, cypher_in, key_load;
    logic [127:0] msg_in [2];
    logic [127:0] key_in [2];
    logic [127:0] rdw    [2];
    logic [1:0]   req_ready, res_valid, busy, rw, adr, init, strt, sel;
    logic [127:0] res_out0, res_out1;
    tri   [31:0]  data0, data1;

    int total  = 0;
    int passed = 0;

    typedef struct packed {
        logic       wr;
        logic       key;
        logic       strt;
        logic       rd;
        logic [7:0] idx;
    } ph_t;

    // Model: 0 idle, 1 in flight (m_t cycles since accept), 2 result held
    int           m_st [2];
    int           m_t  [2];
    logic         m_kl [2];
    logic         m_cy [2];
    logic [127:0] m_msg[2];
    logic [127:0] m_key[2];
    logic [127:0] m_res[2];

    logic [1:0]   tb_en;
    logic [31:0]  tb_val [2];

    aes_bus_master u_dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .msg_in(msg_in[0]), .key_in(key_in[0]),
        .cypher_in(cypher_in[0]), .key_load(key_load[0]),
        .res_valid(res_valid[0]), .res_ready(res_ready[0]), .res_out(res_out0),
        .busy(busy[0]), .data(data0), .RW(rw[0]), .adress(adr[0]),
        .initiate(init[0]), .start(strt[0]), .selCypher(sel[0])
    );

    aes_bus_master #(.ENC_WAIT(5), .DEC_WAIT(3), .RD_LATENCY(2)) u_dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .msg_in(msg_in[1]), .key_in(key_in[1]),
        .cypher_in(cypher_in[1]), .key_load(key_load[1]),
        .res_valid(res_valid[1]), .res_ready(res_ready[1]), .res_out(res_out1),
        .busy(busy[1]), .data(data1), .RW(rw[1]), .adress(adr[1]),
        .initiate(init[1]), .start(strt[1]), .selCypher(sel[1])
    );

    always #5 clk = ~clk;

    function automatic int enc_of(input int i); return (i == 0) ? 36 : 5; endfunction
    function automatic int dec_of(input int i); return (i == 0) ? 23 : 3; endfunction
    function automatic int rl_of (input int i); return (i == 0) ? 1  : 2; endfunction

    function automatic logic [31:0] wd(input logic [127:0] v, input int j);
        logic [127:0] s;
        s = v >> (32 * (3 - j));
        return s[31:0];
    endfunction

    function automatic int total_of(input int i);
        return (m_kl[i] ? 8 : 4) + 1 + (m_cy[i] ? enc_of(i) : dec_of(i)) + rl_of(i) + 4;
    endfunction

    function automatic ph_t phase_of(input int i);
        ph_t p;
        int  nw, w, t;
        p = '0;
        if (m_st[i] != 1) return p;
        t  = m_t[i];
        nw = m_kl[i] ? 8 : 4;
        w  = m_cy[i] ? enc_of(i) : dec_of(i);
        if (t < 4) begin
            p.wr = 1'b1; p.idx = 8'(t);
        end else if (t < nw) begin
            p.wr = 1'b1; p.key = 1'b1; p.idx = 8'(t - 4);
        end else if (t == nw) begin
            p.strt = 1'b1;
        end else if (t > nw + w) begin
            p.rd = 1'b1; p.idx = 8'(t - nw - w - 1);
        end
        return p;
    endfunction

    always @(posedge clk or negedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                m_st[i] <= 0;
                m_t[i]  <= 0;
            end else begin
                case (m_st[i])
                    0: if (req_valid[i]) begin
                        m_st[i]  <= 1;
                        m_t[i]   <= 0;
                        m_kl[i]  <= key_load[i];
                        m_cy[i]  <= cypher_in[i];
                        m_msg[i] <= msg_in[i];
                        m_key[i] <= key_in[i];
                        m_res[i] <= rdw[i];
                    end
                    1: if (m_t[i] == total_of(i) - 1) m_st[i] <= 2;
                       else m_t[i] <= m_t[i] + 1;
                    default: if (res_ready[i]) m_st[i] <= 0;
                endcase
            end
        end
    end

    // Coprocessor side: result words after the read latency, garbage before, probe when idle
    always_comb begin
        tb_en     = 2'b11;
        tb_val[0] = PROBE;
        tb_val[1] = PROBE;
        for (int i = 0; i < 2; i++) begin
            ph_t p;
            p = phase_of(i);
            if (p.wr) tb_en[i] = 1'b0;
            if (p.rd) tb_val[i] = (int'(p.idx) < rl_of(i)) ? 32'hffff_ffff
                                                            : wd(m_res[i], int'(p.idx) - rl_of(i));
        end
    end

    assign data0 = tb_en[0] ? tb_val[0] : 32'hzzzz_zzzz;
    assign data1 = tb_en[1] ? tb_val[1] : 32'hzzzz_zzzz;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            ph_t         p;
            logic [7:0]  ea, aa;
            logic [31:0] ed, ad;
            p  = phase_of(i);
            ea = {m_st[i] == 0, m_st[i] != 0, m_st[i] == 2, p.wr | p.rd, p.wr, p.key, p.strt,
                  (m_st[i] != 0) & m_cy[i]};
            aa = {req_ready[i], busy[i], res_valid[i], init[i], rw[i], adr[i], strt[i], sel[i]};
            check($sformatf("ctl%0d{rdy,busy,val,init,rw,adr,start,sel}", i), 128'(aa), 128'(ea));
            ad = (i == 0) ? data0 : data1;
            ed = p.wr ? wd(p.key ? m_key[i] : m_msg[i], int'(p.idx)) : tb_val[i];
            check($sformatf("data%0d", i), 128'(ad), 128'(ed));
            if (m_st[i] == 2)
                check($sformatf("res_out%0d", i), (i == 0) ? res_out0 : res_out1, m_res[i]);
        end
    end

    task automatic send(input int i, input logic [127:0] m, input logic [127:0] k,
                        input logic cy, input logic kl, input logic [127:0] rd);
        int n;
        msg_in[i] = m; key_in[i] = k; cypher_in[i] = cy; key_load[i] = kl; rdw[i] = rd;
        req_valid[i] = 1'b1;
        n = 0;
        while (!req_ready[i] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("accept_timeout", 128'(n), 128'(0));
        @(negedge clk);
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_resp(input int i, input int exp_lat, input string name);
        int c;
        c = 0;
        while (!res_valid[i] && c < 400) begin
            @(negedge clk);
            c++;
        end
        check(name, 128'(c), 128'(exp_lat));
    endtask

    task automatic consume(input int i);
        res_ready[i] = 1'b1;
        @(negedge clk);
        res_ready[i] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got %0d/%0d", passed, total);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] hold;
        req_valid = '0; res_ready = '0; cypher_in = '0; key_load = '0;
        for (int i = 0; i < 2; i++) begin
            msg_in[i] = '0; key_in[i] = '0; rdw[i] = '0;
        end
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_res_out", res_out0, 128'h0);
        check("rst_ready_busy", 128'({req_ready[0], busy[0], init[0], sel[0]}), 128'(4'b1000));
        reset = 1'b1;
        @(negedge clk);

        // Encrypt with key load
        send(0, 128'h01234567_89abcdef_00112233_44556677, 128'habcdefab_cdefabcd_efabcdef_abcdefab,
             1'b1, 1'b1, 128'hdeadbeef_00000001_12345678_cafef00d);
        check("enc_first_word", 128'(data0), 128'(32'h01234567));
        check("enc_first_ctl", 128'({init[0], rw[0], adr[0], sel[0]}), 128'(4'b1101));
        wait_resp(0, 50, "enc_latency");
        check("enc_result", res_out0, 128'hdeadbeef_00000001_12345678_cafef00d);
        consume(0);

        // Decrypt reusing loaded key
        send(0, {4{32'h76543210}}, 128'h0, 1'b0, 1'b0, 128'h0badf00d_13579bdf_2468ace0_fedcba98);
        check("dec_first_word", 128'(data0), 128'(32'h76543210));
        wait_resp(0, 33, "dec_latency");
        check("dec_result", res_out0, 128'h0badf00d_13579bdf_2468ace0_fedcba98);
        consume(0);

        // Response backpressure with a queued request
        send(0, 128'h1, 128'h2, 1'b1, 1'b0, 128'haaaa5555_0f0f0f0f_f0f0f0f0_12121212);
        wait_resp(0, 46, "bp_latency");
        hold = res_out0;
        check("bp_result", hold, 128'haaaa5555_0f0f0f0f_f0f0f0f0_12121212);
        msg_in[0] = 128'h3; key_in[0] = 128'h4; cypher_in[0] = 1'b0; key_load[0] = 1'b1;
        rdw[0] = 128'h98765432_10fedcba_01010101_babecafe;
        req_valid[0] = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            check("bp_hold", res_out0, hold);
            check("bp_not_ready", 128'(req_ready[0]), 128'(1'b0));
        end
        consume(0);
        check("bp_idle_gap", 128'({req_ready[0], busy[0], init[0]}), 128'(3'b100));
        @(negedge clk);
        req_valid[0] = 1'b0;
        check("bp_queued_accept", 128'({busy[0], init[0], rw[0], adr[0]}), 128'(4'b1110));
        wait_resp(0, 37, "bp_queued_latency");
        check("bp_queued_result", res_out0, 128'h98765432_10fedcba_01010101_babecafe);
        consume(0);

        // Reset while waiting on the coprocessor
        send(0, 128'h5, 128'h6, 1'b1, 1'b1, 128'h77777777_66666666_55555555_44444444);
        repeat (20) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_rst_ctl",
              128'({init[0], strt[0], sel[0], res_valid[0], busy[0], rw[0], adr[0], req_ready[0]}),
              128'(8'b0000_0001));
        check("async_rst_res", res_out0, 128'h0);
        check("async_rst_bus", 128'(data0), 128'(PROBE));
        repeat (3) @(negedge clk);
        reset = 1'b1;
        send(0, 128'h11, 128'h0, 1'b0, 1'b0, 128'h13131313_24242424_35353535_46464646);
        wait_resp(0, 33, "post_rst_latency");
        check("post_rst_result", res_out0, 128'h13131313_24242424_35353535_46464646);
        consume(0);

        // Read latency of 2: garbage on the first two read cycles must be skipped
        send(1, 128'h21, 128'h22, 1'b1, 1'b1, 128'h11111111_22222222_33333333_44444444);
        wait_resp(1, 20, "rl2_latency");
        check("rl2_result", res_out1, 128'h11111111_22222222_33333333_44444444);
        consume(1);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
